// File: rtl/zbb_count_seq.sv
// Iterative clz/ctz/cpop unit: scans the operand CHUNK bits per cycle from the MSB end,
// with early exit for clz/ctz. Start/Ready handshake in, one-cycle Done pulse out.
module zbb_count_seq #(
  parameter int unsigned XLEN  = 64,
  parameter int unsigned CHUNK = 8
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            Start,
  output logic            Ready,
  input  logic [XLEN-1:0] A,
  input  logic [1:0]      Funct,
  input  logic            W,
  input  logic            Flush,
  output logic            Busy,
  output logic            Done,
  output logic [XLEN-1:0] Result
);

  localparam int unsigned CW  = $clog2(XLEN) + 1;
  localparam int unsigned PW  = $clog2(CHUNK) + 1;
  localparam int unsigned NCF = XLEN / CHUNK;
  localparam int unsigned NCW = 32 / CHUNK;
  localparam int unsigned IW  = (NCF > 1) ? $clog2(NCF) : 1;

  localparam logic [1:0] F_CLZ  = 2'b00;
  localparam logic [1:0] F_CTZ  = 2'b01;
  localparam logic [1:0] F_CPOP = 2'b10;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t          state_q, state_n;
  logic [XLEN-1:0] op_q, op_n;
  logic [CW-1:0]   cnt_q, cnt_n;
  logic [IW-1:0]   idx_q, idx_n;
  logic [IW-1:0]   last_q, last_n;
  logic [1:0]      fn_q, fn_n;
  logic [XLEN-1:0] result_n;

  logic [CHUNK-1:0] chunk;
  logic [PW-1:0]    lz_cnt, pop_cnt, add;
  logic             found;
  logic             use_w;
  logic [XLEN-1:0]  a_al, a_rev;
  logic [CW-1:0]    cnt_sum;
  logic             term;

  // Operand is kept MSB-aligned and shifted left each cycle, so chunk i is always the top slice.
  always_comb begin
    chunk   = op_q[XLEN-1 -: CHUNK];
    lz_cnt  = '0;
    pop_cnt = '0;
    found   = 1'b0;
    for (int j = CHUNK - 1; j >= 0; j--) begin
      pop_cnt = pop_cnt + PW'(chunk[j]);
      if (chunk[j]) found = 1'b1;
      else if (!found) lz_cnt = lz_cnt + PW'(1);
    end
    case (fn_q)
      F_CLZ, F_CTZ: add = lz_cnt;
      F_CPOP:       add = pop_cnt;
      default:      add = '0;
    endcase
    cnt_sum = cnt_q + CW'(add);
    case (fn_q)
      F_CLZ, F_CTZ: term = (chunk != '0) || (idx_q == last_q);
      F_CPOP:       term = (idx_q == last_q);
      default:      term = 1'b1;
    endcase
  end

  // Word ops place A[31:0] in the top half; ctz bit-reverses so it reuses the leading-zero scan.
  always_comb begin
    use_w = (XLEN > 32) && W;
    a_al  = use_w ? (A << (XLEN - 32)) : A;
    a_rev = '0;
    for (int j = 0; j < XLEN; j++) begin
      a_rev[XLEN-1-j] = (use_w && j >= 32) ? 1'b0 : A[j];
    end
  end

  always_comb begin
    state_n  = state_q;
    op_n     = op_q;
    cnt_n    = cnt_q;
    idx_n    = idx_q;
    last_n   = last_q;
    fn_n     = fn_q;
    result_n = Result;
    case (state_q)
      IDLE: begin
        if (Start && !Flush) begin
          state_n = RUN;
          op_n    = (Funct == F_CTZ) ? a_rev : a_al;
          cnt_n   = '0;
          idx_n   = '0;
          last_n  = use_w ? IW'(NCW - 1) : IW'(NCF - 1);
          fn_n    = Funct;
        end
      end
      RUN: begin
        cnt_n = cnt_sum;
        op_n  = op_q << CHUNK;
        idx_n = idx_q + IW'(1);
        if (term) begin
          state_n  = DONE;
          result_n = XLEN'(cnt_sum);
        end
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
    // Abort wins over completion; Result keeps its previous value.
    if (Flush) begin
      state_n  = IDLE;
      result_n = Result;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      op_q    <= '0;
      cnt_q   <= '0;
      idx_q   <= '0;
      last_q  <= '0;
      fn_q    <= '0;
      Result  <= '0;
      Ready   <= 1'b1;
      Busy    <= 1'b0;
      Done    <= 1'b0;
    end else begin
      state_q <= state_n;
      op_q    <= op_n;
      cnt_q   <= cnt_n;
      idx_q   <= idx_n;
      last_q  <= last_n;
      fn_q    <= fn_n;
      Result  <= result_n;
      Ready   <= (state_n == IDLE);
      Busy    <= (state_n != IDLE);
      Done    <= (state_n == DONE);
    end
  end

endmodule

// File: tb/tb_zbb_count_seq.sv
// Directed bench for zbb_count_seq: 64-bit instance for function/latency/flush/reset,
// plus a 32-bit instance for held-Start back-to-back behaviour.
module tb_zbb_count_seq;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        Start = 1'b0, Flush = 1'b0, W = 1'b0;
  logic [1:0]  Funct = 2'b00;
  logic [63:0] A = '0;
  logic        Ready, Busy, Done;
  logic [63:0] Result;

  logic        s_start = 1'b0, s_flush = 1'b0, s_w = 1'b0;
  logic [1:0]  s_funct = 2'b00;
  logic [31:0] s_a = '0;
  logic        s_ready, s_busy, s_done;
  logic [31:0] s_result;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  zbb_count_seq #(.XLEN(64), .CHUNK(8)) u_dut (
    .clk(clk), .reset(reset), .Start(Start), .Ready(Ready), .A(A), .Funct(Funct),
    .W(W), .Flush(Flush), .Busy(Busy), .Done(Done), .Result(Result)
  );

  zbb_count_seq #(.XLEN(32), .CHUNK(8)) u_dut32 (
    .clk(clk), .reset(reset), .Start(s_start), .Ready(s_ready), .A(s_a), .Funct(s_funct),
    .W(s_w), .Flush(s_flush), .Busy(s_busy), .Done(s_done), .Result(s_result)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Accept one request, then wait (bounded) for Done; checks Result and Done latency in cycles.
  task automatic run_op(input string tag, input logic [1:0] f, input logic w,
                        input logic [63:0] a, input logic [63:0] er, input int el);
    int   n;
    logic seen;
    Start = 1'b1; Funct = f; W = w; A = a;
    tick();
    Start = 1'b0; Funct = ~f; W = ~w; A = ~a;
    n = 1;
    seen = 1'b0;
    while (!seen && n <= 20) begin
      if (Done) seen = 1'b1;
      else begin
        tick();
        n++;
      end
    end
    chk({tag, " done_seen"}, 64'(seen), 64'd1);
    chk({tag, " latency"}, 64'(n), 64'(el));
    chk({tag, " result"}, Result, er);
    tick();
    chk({tag, " done_pulse_end"}, 64'(Done), 64'd0);
    chk({tag, " ready_after"}, 64'(Ready), 64'd1);
  endtask

  initial begin
    int   d0, d1, nd;
    logic any_done;

    tick(); tick();
    reset = 1'b0;
    chk("reset ready", 64'(Ready), 64'd1);
    chk("reset busy", 64'(Busy), 64'd0);
    chk("reset done", 64'(Done), 64'd0);
    chk("reset result", Result, 64'd0);
    chk("reset32 ready", 64'(s_ready), 64'd1);

    run_op("clz_f0", 2'b00, 1'b0, 64'h0000_0000_00F0_0000, 64'd40, 7);
    run_op("ctz_100", 2'b01, 1'b0, 64'h0000_0000_0000_0100, 64'd8, 3);
    run_op("ctz_zero", 2'b01, 1'b0, 64'h0, 64'd64, 9);
    run_op("cpop_ones", 2'b10, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd64, 9);
    run_op("cpop_ones_w", 2'b10, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 64'd32, 5);
    run_op("clz_w", 2'b00, 1'b1, 64'hFFFF_FFFF_0000_0001, 64'd31, 5);
    run_op("reserved", 2'b11, 1'b0, 64'hFFFF_0000_FFFF_0000, 64'd0, 2);
    run_op("cpop_mix", 2'b10, 1'b0, 64'h0123_4567_89AB_CDEF, 64'd32, 9);
    run_op("clz_w_zero", 2'b00, 1'b1, 64'h0, 64'd32, 5);
    run_op("ctz_w_upper", 2'b01, 1'b1, 64'h8000_0000_0000_0000, 64'd32, 5);
    run_op("ctz_msb", 2'b01, 1'b0, 64'h8000_0000_0000_0000, 64'd63, 9);

    // Flush mid-RUN: no Done, back to IDLE, Result unchanged (63 from previous op).
    Start = 1'b1; Funct = 2'b00; W = 1'b0; A = 64'h0;
    tick();
    Start = 1'b0;
    chk("run busy", 64'(Busy), 64'd1);
    chk("run ready", 64'(Ready), 64'd0);
    tick();
    tick();
    Flush = 1'b1;
    tick();
    Flush = 1'b0;
    chk("flush done", 64'(Done), 64'd0);
    chk("flush ready", 64'(Ready), 64'd1);
    chk("flush result", Result, 64'd63);
    run_op("clz_after_flush", 2'b00, 1'b0, 64'h8000_0000_0000_0000, 64'd0, 2);

    // Flush together with Start in IDLE: not accepted.
    Start = 1'b1; Flush = 1'b1; Funct = 2'b10; A = 64'hFF;
    tick();
    Start = 1'b0; Flush = 1'b0;
    chk("flush_start busy", 64'(Busy), 64'd0);
    chk("flush_start ready", 64'(Ready), 64'd1);
    any_done = 1'b0;
    for (int i = 0; i < 10; i++) begin
      any_done = any_done | Done;
      tick();
    end
    chk("flush_start no_done", 64'(any_done), 64'd0);
    chk("flush_start result", Result, 64'd0);

    // Flush in the DONE cycle: Done already high, then IDLE.
    Start = 1'b1; Funct = 2'b00; W = 1'b0; A = 64'h0100_0000_0000_0000;
    tick();
    Start = 1'b0;
    chk("flushdone pre", 64'(Done), 64'd0);
    tick();
    Flush = 1'b1;
    chk("flushdone done", 64'(Done), 64'd1);
    chk("flushdone result", Result, 64'd7);
    tick();
    Flush = 1'b0;
    chk("flushdone after done", 64'(Done), 64'd0);
    chk("flushdone after ready", 64'(Ready), 64'd1);

    // Reset mid-RUN returns outputs to reset values.
    Start = 1'b1; Funct = 2'b10; A = 64'hFFFF_FFFF_FFFF_FFFF;
    tick();
    Start = 1'b0;
    tick(); tick();
    reset = 1'b1;
    tick();
    chk("rst_run ready", 64'(Ready), 64'd1);
    chk("rst_run busy", 64'(Busy), 64'd0);
    chk("rst_run done", 64'(Done), 64'd0);
    chk("rst_run result", Result, 64'd0);
    reset = 1'b0;
    tick();

    // XLEN=32: Start held high; second accept only in the cycle after Done.
    s_start = 1'b1; s_funct = 2'b10; s_w = 1'b1; s_a = 32'hFFFF_FFFF;
    d0 = -1; d1 = -1; nd = 0;
    for (int c = 0; c <= 13; c++) begin
      if (s_done) begin
        if (nd == 0) d0 = c;
        else if (nd == 1) d1 = c;
        nd++;
      end
      if (c == 1) chk("x32 ready_run", 64'(s_ready), 64'd0);
      if (c == 6) chk("x32 ready_idle", 64'(s_ready), 64'd1);
      tick();
    end
    s_start = 1'b0;
    chk("x32 done_count", 64'(nd), 64'd2);
    chk("x32 first_done", 64'(d0), 64'd5);
    chk("x32 second_done", 64'(d1), 64'd11);
    chk("x32 result", 64'(s_result), 64'd32);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
